// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the 7-segment scan-bus capture block.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package seg_scan_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_BAD   = 4'hE;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] seg;
    } scan_t;

    // Bus value during blanking: no digit selected, all segments dark.
    localparam scan_t SCAN_IDLE = '{sel: 8'hFF, seg: 8'hFF};

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Active-high 7-segment pattern to BCD decoder; unknown patterns map to
// BCD_BAD with the invalid flag raised, a dark digit maps to BCD_BLANK.
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [3:0] o_code,
    output logic       o_invalid
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // through this block leaves a latch behind.
        o_code    = BCD_BAD;
        o_invalid = 1'b0;
        case (i_pattern)
            SEG_0:     o_code = 4'd0;
            SEG_1:     o_code = 4'd1;
            SEG_2:     o_code = 4'd2;
            SEG_3:     o_code = 4'd3;
            SEG_4:     o_code = 4'd4;
            SEG_5:     o_code = 4'd5;
            SEG_6:     o_code = 4'd6;
            SEG_7:     o_code = 4'd7;
            SEG_8:     o_code = 4'd8;
            SEG_9:     o_code = 4'd9;
            SEG_BLANK: o_code = BCD_BLANK;
            default:   o_invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of a multiplexed 7-segment scan bus: filters, decodes and
// assembles the eight scanned digits into frames with a one-cycle strobe.
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 1000000
) (
    input  logic        CP,
    input  logic        CR,
    input  logic [7:0]  sel,
    input  logic [7:0]  seg,
    output logic [31:0] digits,
    output logic [7:0]  blank_mask,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        stale
);

    localparam logic [7:0]  STAB_MAX = 8'(SETTLE - 1);
    localparam logic [23:0] IDLE_MAX = 24'(TIMEOUT - 1);

    scan_t       r_sync;
    scan_t       r_cur;
    scan_t       r_prev;
    logic [7:0]  r_stab_cnt;
    logic        r_captured;
    logic [7:0]  r_seen;
    logic [7:0]  r_bad;
    logic [3:0]  r_shadow [NUM_DIGITS];
    logic [23:0] r_idle_cnt;
    logic [31:0] r_digits;
    logic [7:0]  r_blank_mask;
    logic        r_frame_valid;
    logic        r_frame_err;
    logic        r_stale;

    logic [7:0]  w_sel_act;
    logic [6:0]  w_pattern;
    logic [3:0]  w_code;
    logic        w_invalid;
    logic [2:0]  w_idx;
    logic        w_same;
    logic [7:0]  w_stab_next;
    logic        w_accept;
    logic        w_complete;
    logic        w_timeout;
    logic [7:0]  w_seen_next;
    logic [7:0]  w_bad_next;
    logic [31:0] w_shadow_flat;
    logic [7:0]  w_shadow_blank;

    assign w_sel_act = ~r_cur.sel;
    assign w_pattern = ~r_cur.seg[6:0];
    assign w_idx     = onehot_index(w_sel_act);
    assign w_same    = (r_cur == r_prev);

    seg7_decode u_decode (
        .i_pattern (w_pattern),
        .o_code    (w_code),
        .o_invalid (w_invalid)
    );

    always_comb begin
        w_stab_next = 8'd0;
        if (w_same) begin
            w_stab_next = (r_stab_cnt == STAB_MAX) ? r_stab_cnt : r_stab_cnt + 8'd1;
        end
    end

    // Accept in the cycle the SETTLE-th identical sample sits in cur, once per window.
    assign w_accept   = (w_stab_next == STAB_MAX) && !r_captured && is_onehot(w_sel_act);
    assign w_complete = (r_seen == 8'hFF);
    assign w_timeout  = (r_idle_cnt == IDLE_MAX) && !w_accept;

    // Clearing first and then applying the accept keeps a digit that lands
    // in the completion or timeout cycle as the start of the next frame.
    always_comb begin
        w_seen_next = r_seen;
        w_bad_next  = r_bad;
        if (w_complete || w_timeout) begin
            w_seen_next = 8'd0;
            w_bad_next  = 8'd0;
        end
        if (w_accept) begin
            w_seen_next[w_idx] = 1'b1;
            w_bad_next[w_idx]  = w_invalid;
        end
    end

    always_comb begin
        w_shadow_flat  = 32'd0;
        w_shadow_blank = 8'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_shadow_flat[4*i +: 4] = r_shadow[i];
            w_shadow_blank[i]       = (r_shadow[i] == BCD_BLANK);
        end
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            r_sync        <= SCAN_IDLE;
            r_cur         <= SCAN_IDLE;
            r_prev        <= SCAN_IDLE;
            r_stab_cnt    <= 8'd0;
            r_captured    <= 1'b0;
            r_seen        <= 8'd0;
            r_bad         <= 8'd0;
            r_idle_cnt    <= 24'd0;
            r_digits      <= 32'hFFFF_FFFF;
            r_blank_mask  <= 8'hFF;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_stale       <= 1'b1;
            // NOTE: the shadow array is only eight nibbles, so it is reset
            // like ordinary flops; a large RAM-style array would not be.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= BCD_BLANK;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // flop samples the pre-edge values of its neighbours.
            r_sync     <= '{sel: sel, seg: seg};
            r_cur      <= r_sync;
            r_prev     <= r_cur;
            r_stab_cnt <= w_stab_next;
            r_captured <= w_same && (r_captured || w_accept);
            r_seen     <= w_seen_next;
            r_bad      <= w_bad_next;
            r_idle_cnt <= (w_accept || w_timeout) ? 24'd0 : r_idle_cnt + 24'd1;

            if (w_accept) begin
                r_shadow[w_idx] <= w_code;
            end

            r_frame_valid <= w_complete;
            if (w_complete) begin
                r_digits     <= w_shadow_flat;
                r_blank_mask <= w_shadow_blank;
                r_frame_err  <= |r_bad;
                r_stale      <= 1'b0;
            end else if (w_timeout) begin
                r_stale <= 1'b1;
            end
        end
    end

    assign digits      = r_digits;
    assign blank_mask  = r_blank_mask;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign stale       = r_stale;

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the multiplexed 7-segment scan bus (sel/seg) driven by the clock top.
- Samples the scanned bus and decodes each digit's segment pattern back to BCD.
- Assembles all 8 digits into a frame and publishes the frame with a one-cycle valid strobe.
- Used for board-level self-check of the clock display path, or to forward the displayed time to another board.

Parameters:
- SETTLE, 8: consecutive identical CP samples of {sel,seg} required before a digit is accepted; legal range 2..255.
- TIMEOUT, 1000000: CP cycles with no accepted digit before the partial frame is discarded and stale is raised; legal range 16..2^24-1.

Ports:
- CP  input  1  system clock; all state on rising edge.
- CR  input  1  reset, asynchronous, active-high.
- sel  input  8  digit select, active-low; bit i low = digit i driven; all ones = blanking interval.
- seg  input  8  segments, active-low, {dp,g,f,e,d,c,b,a}; dp ignored.
- digits  output  32  frame of 8 BCD codes, digit i at [4i+3:4i]; 4'hF = blank, 4'hE = invalid pattern.
- blank_mask  output  8  bit i = digit i was dark (all segments off) in the last frame.
- frame_valid  output  1  one-cycle pulse when digits/blank_mask/frame_err update.
- frame_err  output  1  last frame contained an invalid pattern (bit-level OR of per-digit bad flags).
- stale  output  1  high from reset or timeout until the next frame_valid.

Behaviour:
- Reset (async, CR=1):
  - digits=32'hFFFFFFFF, blank_mask=8'hFF, frame_valid=0, frame_err=0, stale=1.
  - Internal: seen=0, bad=0, stab_cnt=0, captured=0, idle_cnt=0.
  - CR asserted mid-frame discards the partial frame; no frame_valid follows.
- Input stage:
  - {sel,seg} is registered through two flops (metastability); all later logic uses the second stage (cur) and the prior sample (prev).
- Stability filter:
  - cur!=prev: stab_cnt<=0, captured<=0.
  - Otherwise stab_cnt saturates at SETTLE-1.
- Accept condition (one cycle per stable window): stab_cnt==SETTLE-1, captured==0, and ~cur_sel is exactly one-hot.
  - On accept: captured<=1; shadow[i]<=decode(~cur_seg[6:0]); seen[i]<=1; bad[i]<=invalid.
  - sel all ones, or more than one bit low: never accepted; no error flagged.
- Decode (active-high g..a after inversion):
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9.
  - 00 = blank (4'hF).
  - Any other pattern = 4'hE and bad.
- Re-accepting a digit before the frame completes overwrites it; the newest value wins.
- Frame completion:
  - Evaluated on the registered seen==8'hFF, so outputs update one cycle after the completing accept.
  - That cycle: digits<=shadow, blank_mask<=bit i=(shadow[i]==F), frame_err<=|bad, frame_valid=1, stale<=0, seen<=0, bad<=0.
  - An accept landing in the same cycle as completion is kept: it starts the next frame (its seen/bad bits survive the clear).
- Timeout:
  - idle_cnt increments every cycle and clears on each accept.
  - At idle_cnt==TIMEOUT-1: seen<=0, bad<=0, stale<=1.
  - digits and blank_mask hold their last values.
- frame_valid is never high two cycles in a row; minimum frame spacing is 8*SETTLE cycles.

Decomposition:
- Shared package seg_scan_pkg:
  - SEG_0..SEG_9 and SEG_BLANK pattern constants.
  - BCD_BLANK=4'hF, BCD_BAD=4'hE.
  - NUM_DIGITS=8.
- Sub-module seg7_decode: combinational 7-bit active-high pattern in; 4-bit code and invalid flag out. Instantiated once on the cur sample.
- Everything else lives in seg_scan_capture.

Test Plan:
- Reset with SETTLE=4: CR pulse -> digits=FFFFFFFF, blank_mask=FF, stale=1, frame_valid=0.
- Full scan, sel stepping FE,FD..7F, 6 cycles per digit, displaying 12-34-56 (digits 7..0 = 1,2,F,3,4,F,5,6, blanks seg=FF) -> one frame_valid pulse one cycle after the digit-7 accept; digits=32'h12F34F56, blank_mask=8'h24, frame_err=0, stale=0.
- Glitch filter: a digit held only 3 cycles (SETTLE=4) -> not accepted; no frame_valid until that digit is rescanned for at least 4 cycles.
- Invalid pattern: digit 3 shows active-high 0x49 -> digits[15:12]=E, frame_err=1; the next clean frame clears frame_err=0.
- Illegal sel: sel=8'hFC held 20 cycles -> no accept, seen unchanged; scan resumes and completes normally.
- Timeout with TIMEOUT=100: stop after 5 digits and idle 100 cycles -> stale=1, digits keep the prior frame; the next full scan pulses frame_valid with no bits carried over from the partial frame.
